// File: rtl/fcvt_i2f_ctrl.sv
// Sequencing controller for FCVT.S.W / FCVT.S.WU around a shared combinational
// unsigned integer-to-float converter: sign/magnitude split, rm resolution, NX and result hold.
module fcvt_i2f_ctrl #(
   parameter int unsigned ID_W = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_src,
   input  logic            in_signed,
   input  logic [2:0]      in_rm,
   input  logic [ID_W-1:0] in_rd,
   input  logic [2:0]      frm,
   input  logic            flush,
   output logic [31:0]     cvt_int,
   output logic [2:0]      cvt_rm,
   input  logic [31:0]     cvt_result,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_result,
   output logic            out_nx,
   output logic            out_illegal,
   output logic [ID_W-1:0] out_rd
);

   localparam int unsigned XW  = 32;
   localparam int unsigned RMW = 3;
   localparam int unsigned SIG_W = 24;

   localparam logic [RMW-1:0] RM_RDN = 3'b010;
   localparam logic [RMW-1:0] RM_RUP = 3'b011;
   localparam logic [RMW-1:0] RM_DYN = 3'b111;

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t state, next_state;

   logic           neg_q, ill_q;
   logic           in_neg_c, in_ill_c;
   logic [XW-1:0]  in_mag_c;
   logic [RMW-1:0] eff_rm_c, conv_rm_c;
   logic [XW-1:0]  smear_c;
   logic           nx_c;
   logic           accept_c, capture_c, in_ready_d, out_valid_d;
   logic           unused_c;

   // Converter output is always non-negative; its sign bit carries no information.
   assign unused_c = cvt_result[XW-1];

   // Operand preparation: sign/magnitude split and rounding-mode resolution.
   always_comb begin
      in_neg_c  = in_signed & in_src[XW-1];
      in_mag_c  = in_neg_c ? (~in_src + XW'(1)) : in_src;
      eff_rm_c  = (in_rm == RM_DYN) ? frm : in_rm;
      in_ill_c  = (eff_rm_c == 3'b101) || (eff_rm_c == 3'b110) || (eff_rm_c == 3'b111);
      conv_rm_c = eff_rm_c;
      // Directed modes flip when rounding a magnitude that will be negated.
      if (in_neg_c && (eff_rm_c == RM_RDN)) conv_rm_c = RM_RUP;
      if (in_neg_c && (eff_rm_c == RM_RUP)) conv_rm_c = RM_RDN;
   end

   // NX: any set bit below the 24 significant bits that start at the MSB.
   always_comb begin
      smear_c = cvt_int;
      smear_c = smear_c | (smear_c >> 1);
      smear_c = smear_c | (smear_c >> 2);
      smear_c = smear_c | (smear_c >> 4);
      smear_c = smear_c | (smear_c >> 8);
      smear_c = smear_c | (smear_c >> 16);
      nx_c    = |(cvt_int & (smear_c >> SIG_W));
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (in_valid) next_state = CONV;
         CONV:    next_state = DONE;
         DONE:    if (out_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
      if (flush) next_state = IDLE;
   end

   always_comb begin
      accept_c    = 1'b0;
      capture_c   = 1'b0;
      in_ready_d  = (next_state == IDLE);
      out_valid_d = (next_state == DONE);
      if ((state == IDLE) && in_valid && !flush) accept_c  = 1'b1;
      if ((state == CONV) && !flush)             capture_c = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         out_result  <= '0;
         out_nx      <= 1'b0;
         out_illegal <= 1'b0;
         out_rd      <= '0;
         cvt_int     <= '0;
         cvt_rm      <= '0;
         neg_q       <= 1'b0;
         ill_q       <= 1'b0;
      end else begin
         in_ready  <= in_ready_d;
         out_valid <= out_valid_d;
         if (accept_c) begin
            cvt_int <= in_mag_c;
            cvt_rm  <= conv_rm_c;
            neg_q   <= in_neg_c;
            ill_q   <= in_ill_c;
            out_rd  <= in_rd;
         end
         if (capture_c) begin
            out_result  <= ill_q ? '0 : {neg_q, cvt_result[XW-2:0]};
            out_nx      <= !ill_q && nx_c;
            out_illegal <= ill_q;
         end
      end
   end

endmodule

// File: tb/tb_fcvt_i2f_ctrl.sv
// Bench for fcvt_i2f_ctrl: models the unsigned converter, scoreboards expected
// results at request time and compares them when the DUT presents its output.
module tb_fcvt_i2f_ctrl;

   localparam int unsigned ID_W = 5;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_src;
   logic            in_signed;
   logic [2:0]      in_rm;
   logic [ID_W-1:0] in_rd;
   logic [2:0]      frm;
   logic            flush;
   logic [31:0]     cvt_int;
   logic [2:0]      cvt_rm;
   logic [31:0]     cvt_result;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_result;
   logic            out_nx;
   logic            out_illegal;
   logic [ID_W-1:0] out_rd;

   typedef struct {
      logic [31:0]     res;
      logic            nx;
      logic            ill;
      logic [ID_W-1:0] rd;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   fcvt_i2f_ctrl #(.ID_W(ID_W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_src(in_src),
      .in_signed(in_signed), .in_rm(in_rm), .in_rd(in_rd), .frm(frm),
      .flush(flush), .cvt_int(cvt_int), .cvt_rm(cvt_rm), .cvt_result(cvt_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_nx(out_nx), .out_illegal(out_illegal), .out_rd(out_rd)
   );

   always #5 clk = ~clk;

   // Reference unsigned int -> single converter (magnitude is always positive).
   function automatic logic [31:0] u2f(input logic [31:0] m, input logic [2:0] rm);
      int          p, sh, e;
      logic [63:0] sig, rem, half;
      logic        inc;
      if (m == 32'd0) return 32'd0;
      p = 0;
      for (int i = 0; i < 32; i++) if (m[i]) p = i;
      if (p <= 23) begin
         sig = 64'(m) << (23 - p);
         return {1'b0, 8'(127 + p), sig[22:0]};
      end
      sh   = p - 23;
      sig  = 64'(m) >> sh;
      rem  = 64'(m) & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      case (rm)
         3'b000:  inc = (rem > half) || ((rem == half) && sig[0]);
         3'b011:  inc = (rem != 64'd0);
         3'b100:  inc = (rem >= half);
         default: inc = 1'b0;
      endcase
      sig = sig + 64'(inc);
      e   = 127 + p;
      if (sig[24]) begin
         sig = sig >> 1;
         e   = e + 1;
      end
      return {1'b0, 8'(e), sig[22:0]};
   endfunction

   assign cvt_result = u2f(cvt_int, cvt_rm);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic chk_reset_state();
      chk("rst_in_ready",    64'(in_ready),    64'd1);
      chk("rst_out_valid",   64'(out_valid),   64'd0);
      chk("rst_out_result",  64'(out_result),  64'd0);
      chk("rst_out_nx",      64'(out_nx),      64'd0);
      chk("rst_out_illegal", 64'(out_illegal), 64'd0);
      chk("rst_out_rd",      64'(out_rd),      64'd0);
      chk("rst_cvt_int",     64'(cvt_int),     64'd0);
      chk("rst_cvt_rm",      64'(cvt_rm),      64'd0);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 20) begin
         step();
         n++;
      end
      chk("in_ready_wait", 64'(in_ready), 64'd1);
   endtask

   // Full transaction: push expectation, drive, check latency/cvt bus, hold, pop, release.
   task automatic do_req(input logic [31:0] src, input logic sgn, input logic [2:0] rm,
                         input logic [2:0] fv, input logic [ID_W-1:0] rd,
                         input logic [31:0] e_mag, input logic [2:0] e_crm,
                         input logic [31:0] e_res, input logic e_nx, input logic e_ill,
                         input int hold);
      exp_t e;
      e.res = e_res; e.nx = e_nx; e.ill = e_ill; e.rd = rd;
      sb.push_back(e);
      wait_ready();
      in_valid = 1'b1; in_src = src; in_signed = sgn; in_rm = rm; frm = fv; in_rd = rd;
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      chk("conv_out_valid", 64'(out_valid), 64'd0);
      chk("conv_in_ready",  64'(in_ready),  64'd0);
      chk("conv_cvt_int",   64'(cvt_int),   64'(e_mag));
      if (!e_ill) chk("conv_cvt_rm", 64'(cvt_rm), 64'(e_crm));
      step();
      chk("latency_out_valid", 64'(out_valid), 64'd1);
      e = sb.pop_front();
      chk("out_result",  64'(out_result),  64'(e.res));
      chk("out_nx",      64'(out_nx),      64'(e.nx));
      chk("out_illegal", 64'(out_illegal), 64'(e.ill));
      chk("out_rd",      64'(out_rd),      64'(e.rd));
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         in_src   = ~src;
         in_rd    = ~rd;
         step();
         chk("hold_out_valid", 64'(out_valid),  64'd1);
         chk("hold_result",    64'(out_result), 64'(e.res));
         chk("hold_rd",        64'(out_rd),     64'(e.rd));
         chk("hold_in_ready",  64'(in_ready),   64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("release_in_ready",  64'(in_ready),  64'd1);
      chk("release_out_valid", 64'(out_valid), 64'd0);
   endtask

   // Independent expectation for random traffic.
   task automatic rand_req();
      logic [31:0] src, mag, res, rem_mask;
      logic        sgn, neg, ill, nx;
      logic [2:0]  rm, fv, eff, crm;
      int          p;
      src = $urandom();
      if ($urandom_range(0, 3) == 0) src = src >> $urandom_range(8, 31);
      sgn = 1'($urandom_range(0, 1));
      rm  = 3'($urandom_range(0, 7));
      fv  = 3'($urandom_range(0, 7));
      neg = sgn && src[31];
      mag = neg ? (32'd0 - src) : src;
      eff = (rm == 3'b111) ? fv : rm;
      ill = (eff >= 3'b101);
      crm = eff;
      if (neg && eff == 3'b010) crm = 3'b011;
      else if (neg && eff == 3'b011) crm = 3'b010;
      p = -1;
      for (int i = 0; i < 32; i++) if (mag[i]) p = i;
      nx = 1'b0;
      if (p > 23) begin
         rem_mask = (32'd1 << (p - 23)) - 32'd1;
         nx = ((mag & rem_mask) != 32'd0);
      end
      res = u2f(mag, crm);
      res[31] = neg;
      if (ill) begin
         res = 32'd0;
         nx  = 1'b0;
      end
      do_req(src, sgn, rm, fv, 5'($urandom_range(0, 31)), mag, crm, res, nx, ill, 0);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_src = '0; in_signed = 1'b0; in_rm = '0;
      in_rd = '0; frm = '0; flush = 1'b0; out_ready = 1'b0;
      step();
      chk_reset_state();
      reset = 1'b0;
      step();

      do_req(32'hFFFF_FFFF, 1'b1, 3'b000, 3'b000, 5'd1,  32'h0000_0001, 3'b000, 32'hBF80_0000, 1'b0, 1'b0, 0);
      do_req(32'hFFFF_FFFF, 1'b0, 3'b001, 3'b000, 5'd2,  32'hFFFF_FFFF, 3'b001, 32'h4F7F_FFFF, 1'b1, 1'b0, 3);
      do_req(32'hFFFF_FFFF, 1'b0, 3'b000, 3'b000, 5'd3,  32'hFFFF_FFFF, 3'b000, 32'h4F80_0000, 1'b1, 1'b0, 0);
      do_req(32'h8000_0000, 1'b1, 3'b000, 3'b000, 5'd4,  32'h8000_0000, 3'b000, 32'hCF00_0000, 1'b0, 1'b0, 0);
      do_req(32'h0000_0000, 1'b1, 3'b000, 3'b000, 5'd5,  32'h0000_0000, 3'b000, 32'h0000_0000, 1'b0, 1'b0, 0);
      do_req(32'hFEFF_FFFF, 1'b1, 3'b010, 3'b000, 5'd6,  32'h0100_0001, 3'b011, 32'hCB80_0001, 1'b1, 1'b0, 0);
      do_req(32'hFEFF_FFFF, 1'b1, 3'b111, 3'b010, 5'd7,  32'h0100_0001, 3'b011, 32'hCB80_0001, 1'b1, 1'b0, 0);
      do_req(32'hFEFF_FFFF, 1'b1, 3'b101, 3'b000, 5'd8,  32'h0100_0001, 3'b000, 32'h0000_0000, 1'b0, 1'b1, 0);
      do_req(32'h0000_0005, 1'b0, 3'b111, 3'b110, 5'd9,  32'h0000_0005, 3'b000, 32'h0000_0000, 1'b0, 1'b1, 0);
      do_req(32'h0100_0001, 1'b0, 3'b010, 3'b000, 5'd10, 32'h0100_0001, 3'b010, 32'h4B80_0000, 1'b1, 1'b0, 1);

      for (int i = 0; i < 24; i++) rand_req();

      // Flush while converting: the operation disappears.
      wait_ready();
      in_valid = 1'b1; in_src = 32'h1234_5678; in_signed = 1'b0; in_rm = 3'b000; in_rd = 5'd20;
      step();
      in_valid = 1'b0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_conv_out_valid", 64'(out_valid), 64'd0);
      chk("flush_conv_in_ready",  64'(in_ready),  64'd1);
      step();
      chk("flush_conv_no_valid",  64'(out_valid), 64'd0);

      // Flush coincident with a request in IDLE blocks acceptance.
      in_valid = 1'b1; flush = 1'b1;
      step();
      in_valid = 1'b0; flush = 1'b0;
      chk("flush_idle_in_ready", 64'(in_ready), 64'd1);
      step();
      chk("flush_idle_no_valid", 64'(out_valid), 64'd0);

      // Reset while holding a result.
      in_valid = 1'b1; in_src = 32'hFFFF_FFF0; in_signed = 1'b1; in_rm = 3'b001; in_rd = 5'd21;
      step();
      in_valid = 1'b0;
      step();
      chk("pre_reset_out_valid", 64'(out_valid), 64'd1);
      chk("pre_reset_result",    64'(out_result), 64'hC180_0000);
      reset = 1'b1;
      step();
      chk_reset_state();
      reset = 1'b0;
      step();

      do_req(32'h0000_0003, 1'b1, 3'b100, 3'b000, 5'd31, 32'h0000_0003, 3'b100, 32'h4040_0000, 1'b0, 1'b0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
